// File: rtl/gpu_pixel_writeback_if.sv
// ---------------------------------------------------------------------------
// gpu_pixel_writeback_if
// Handshake bundle for the pixel write-back block.
//   Pixel side : i_valid/o_ready plus pixel coordinates, colour and flags
//   VRAM side  : o_wr_valid/i_wr_ready plus word address, data and half-select
// Modports:
//   slave  - the write-back block (consumes pixels, produces VRAM writes)
//   master - the environment (blend stage + VRAM arbiter)
// ---------------------------------------------------------------------------
interface gpu_pixel_writeback_if #(
    parameter int XW = 10,
    parameter int YW = 9
) ();
    logic                 i_valid;
    logic                 o_ready;
    logic [XW-1:0]        i_x;
    logic [YW-1:0]        i_y;
    logic [7:0]           i_r;
    logic [7:0]           i_g;
    logic [7:0]           i_b;
    logic                 i_stp;
    logic                 i_ditherOn;
    logic                 i_forceMask;
    logic                 o_wr_valid;
    logic                 i_wr_ready;
    logic [YW+XW-2:0]     o_wr_addr;
    logic [31:0]          o_wr_data;
    logic [1:0]           o_wr_sel;

    modport slave (
        input  i_valid, i_x, i_y, i_r, i_g, i_b, i_stp, i_ditherOn, i_forceMask,
        input  i_wr_ready,
        output o_ready, o_wr_valid, o_wr_addr, o_wr_data, o_wr_sel
    );

    modport master (
        output i_valid, i_x, i_y, i_r, i_g, i_b, i_stp, i_ditherOn, i_forceMask,
        output i_wr_ready,
        input  o_ready, o_wr_valid, o_wr_addr, o_wr_data, o_wr_sel
    );
endinterface

// File: rtl/gpu_pixel_writeback.sv
// ---------------------------------------------------------------------------
// gpu_pixel_writeback
// Final stage of the pixel path: optional 4x4 ordered dither, conversion of
// 8:8:8 colour to the 15-bit VRAM format plus mask bit, and pairing of
// horizontally adjacent pixels into 32-bit VRAM word writes.
// Ports:
//   clk     - system clock
//   i_nrst  - asynchronous active-low reset
//   bus     - pixel input and VRAM write handshakes (slave modport)
//   i_flush - one-cycle request to drain a held even pixel
//   o_idle  - no pixel held anywhere in the block
// Pipeline: S1 (converted pixel) -> P (even pixel waiting for its partner)
//           -> OUT (registered VRAM write).
// ---------------------------------------------------------------------------
module gpu_pixel_writeback #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic                  clk,
    input  logic                  i_nrst,
    gpu_pixel_writeback_if.slave  bus,
    input  logic                  i_flush,
    output logic                  o_idle
);
    localparam int AW = YW + XW - 1;

    // Ordered-dither offset for a screen position (rows indexed by y).
    function automatic logic signed [9:0] dither_offset(input logic [1:0] y, input logic [1:0] x);
        case ({y, x})
            4'h0:    return -10'sd4;
            4'h1:    return  10'sd0;
            4'h2:    return -10'sd3;
            4'h3:    return  10'sd1;
            4'h4:    return  10'sd2;
            4'h5:    return -10'sd2;
            4'h6:    return  10'sd3;
            4'h7:    return -10'sd1;
            4'h8:    return -10'sd3;
            4'h9:    return  10'sd1;
            4'hA:    return -10'sd4;
            4'hB:    return  10'sd0;
            4'hC:    return  10'sd3;
            4'hD:    return -10'sd1;
            4'hE:    return  10'sd2;
            4'hF:    return -10'sd2;
            default: return  10'sd0;
        endcase
    endfunction

    // Add the dither offset, saturate to 0..255 and keep the top five bits.
    function automatic logic [4:0] chan5(input logic [7:0] c, input logic signed [9:0] d);
        logic signed [9:0] sum;
        logic [7:0]        sat;
        sum = $signed({2'b00, c}) + d;
        if (sum < 10'sd0) begin
            sat = 8'h00;
        end else if (sum > 10'sd255) begin
            sat = 8'hFF;
        end else begin
            sat = sum[7:0];
        end
        return sat[7:3];
    endfunction

    logic              s1_valid_r;
    logic              s1_odd_r;
    logic [AW-1:0]     s1_addr_r;
    logic [15:0]       s1_pix_r;
    logic              p_valid_r;
    logic [AW-1:0]     p_addr_r;
    logic [15:0]       p_pix_r;
    logic              out_valid_r;
    logic [AW-1:0]     out_addr_r;
    logic [31:0]       out_data_r;
    logic [1:0]        out_sel_r;
    logic              flush_req_r;

    logic signed [9:0] dith_s;
    logic [15:0]       cap_pix_s;
    logic              out_free_s;
    logic              consume_s;
    logic              accept_s;
    logic              p_load_s;
    logic              p_clear_s;
    logic              out_load_s;
    logic [AW-1:0]     out_addr_s;
    logic [31:0]       out_data_s;
    logic [1:0]        out_sel_s;

    // Conversion of the incoming pixel to the 16-bit VRAM format.
    always_comb begin
        dith_s = 10'sd0;
        if (bus.i_ditherOn) begin
            dith_s = dither_offset(bus.i_y[1:0], bus.i_x[1:0]);
        end else begin
            dith_s = 10'sd0;
        end
        cap_pix_s = {bus.i_stp | bus.i_forceMask,
                     chan5(bus.i_b, dith_s),
                     chan5(bus.i_g, dith_s),
                     chan5(bus.i_r, dith_s)};
    end

    assign out_free_s = !out_valid_r || bus.i_wr_ready;

    // Merge decision: what S1/P contribute to OUT this cycle.
    always_comb begin
        consume_s  = 1'b0;
        p_load_s   = 1'b0;
        p_clear_s  = 1'b0;
        out_load_s = 1'b0;
        out_addr_s = p_addr_r;
        out_data_s = 32'h0000_0000;
        out_sel_s  = 2'b00;
        if (s1_valid_r && out_free_s) begin
            if (!p_valid_r) begin
                if (!s1_odd_r) begin
                    p_load_s  = 1'b1;
                    consume_s = 1'b1;
                end else begin
                    out_load_s = 1'b1;
                    out_addr_s = s1_addr_r;
                    out_data_s = {s1_pix_r, 16'h0000};
                    out_sel_s  = 2'b10;
                    consume_s  = 1'b1;
                end
            end else if (s1_odd_r && (s1_addr_r == p_addr_r)) begin
                out_load_s = 1'b1;
                out_data_s = {s1_pix_r, p_pix_r};
                out_sel_s  = 2'b11;
                p_clear_s  = 1'b1;
                consume_s  = 1'b1;
            end else begin
                // Partner never arrived: emit the even half alone and keep S1
                // for re-evaluation against an empty P next cycle.
                out_load_s = 1'b1;
                out_data_s = {16'h0000, p_pix_r};
                out_sel_s  = 2'b01;
                p_clear_s  = 1'b1;
            end
        end else if (!s1_valid_r && p_valid_r && flush_req_r && out_free_s) begin
            out_load_s = 1'b1;
            out_data_s = {16'h0000, p_pix_r};
            out_sel_s  = 2'b01;
            p_clear_s  = 1'b1;
        end else begin
            consume_s = 1'b0;
        end
    end

    assign bus.o_ready = !flush_req_r && (!s1_valid_r || consume_s);
    assign accept_s    = bus.i_valid && bus.o_ready;

    // S1: holds the converted pixel until the merge logic takes it.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            s1_valid_r <= 1'b0;
            s1_odd_r   <= 1'b0;
            s1_addr_r  <= '0;
            s1_pix_r   <= 16'h0000;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_odd_r   <= bus.i_x[0];
            s1_addr_r  <= {bus.i_y, bus.i_x[XW-1:1]};
            s1_pix_r   <= cap_pix_s;
        end else if (consume_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // P: even pixel waiting for its odd neighbour.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            p_valid_r <= 1'b0;
            p_addr_r  <= '0;
            p_pix_r   <= 16'h0000;
        end else if (p_load_s) begin
            p_valid_r <= 1'b1;
            p_addr_r  <= s1_addr_r;
            p_pix_r   <= s1_pix_r;
        end else if (p_clear_s) begin
            p_valid_r <= 1'b0;
        end else begin
            p_valid_r <= p_valid_r;
        end
    end

    // OUT: registered VRAM write, frozen while the arbiter stalls.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_data_r  <= 32'h0000_0000;
            out_sel_r   <= 2'b00;
        end else if (out_load_s) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= out_addr_s;
            out_data_r  <= out_data_s;
            out_sel_r   <= out_sel_s;
        end else if (bus.i_wr_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky flush request; a new request wins over the clear condition so a
    // pixel accepted alongside i_flush is still drained.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            flush_req_r <= 1'b0;
        end else if (i_flush) begin
            flush_req_r <= 1'b1;
        end else if (!s1_valid_r && !p_valid_r) begin
            flush_req_r <= 1'b0;
        end else begin
            flush_req_r <= flush_req_r;
        end
    end

    assign bus.o_wr_valid = out_valid_r;
    assign bus.o_wr_addr  = out_addr_r;
    assign bus.o_wr_data  = out_data_r;
    assign bus.o_wr_sel   = out_sel_r;
    assign o_idle         = !s1_valid_r && !p_valid_r && !out_valid_r;

endmodule

// File: tb/tb_gpu_pixel_writeback.sv
// ---------------------------------------------------------------------------
// tb_gpu_pixel_writeback
// Directed self-checking bench for gpu_pixel_writeback. Inputs change on the
// falling edge; outputs are sampled on the falling edge (or #1 after it).
// ---------------------------------------------------------------------------
module tb_gpu_pixel_writeback;
    logic clk;
    logic i_nrst;
    logic i_flush;
    logic o_idle;
    int   checks = 0;
    int   errors = 0;

    gpu_pixel_writeback_if #(.XW(10), .YW(9)) bus ();

    gpu_pixel_writeback #(.XW(10), .YW(9)) dut (
        .clk    (clk),
        .i_nrst (i_nrst),
        .bus    (bus),
        .i_flush(i_flush),
        .o_idle (o_idle)
    );

    // {valid, sel, addr, data}
    logic [52:0] wr_obs;
    assign wr_obs = {bus.o_wr_valid, bus.o_wr_sel, bus.o_wr_addr, bus.o_wr_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_pix(input logic [9:0] x, input logic [8:0] y, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b, input logic stp,
                           input logic dith, input logic fm);
        bus.i_valid     = 1'b1;
        bus.i_x         = x;
        bus.i_y         = y;
        bus.i_r         = r;
        bus.i_g         = g;
        bus.i_b         = b;
        bus.i_stp       = stp;
        bus.i_ditherOn  = dith;
        bus.i_forceMask = fm;
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_wr_ready = 1'b1;
        set_pix(10'd0, 9'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.o_wr_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_valid got %b want 0", bus.o_wr_valid); end
        checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", o_idle); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.o_ready); end
        i_nrst = 1'b1;
        // Put traffic in flight with the arbiter stalled, then reset mid-cycle.
        bus.i_wr_ready = 1'b0;
        set_pix(10'd1, 9'd0, 8'hF8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_pix(10'd4, 9'd0, 8'hF8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        checks++; if (bus.o_wr_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_wr_valid got %b want 1", bus.o_wr_valid); end
        checks++; if (o_idle !== 1'b0) begin errors++; $display("FAIL pre_rst_idle got %b want 0", o_idle); end
        #2 i_nrst = 1'b0;
        #1;
        checks++; if (bus.o_wr_valid !== 1'b0) begin errors++; $display("FAIL async_rst_wr_valid got %b want 0", bus.o_wr_valid); end
        checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL async_rst_idle got %b want 1", o_idle); end
        @(negedge clk);
        i_nrst = 1'b1;
        bus.i_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.o_wr_valid !== 1'b0 || o_idle !== 1'b1) begin
                errors++; $display("FAIL post_rst_quiet cyc %0d got valid=%b idle=%b want 0/1", i, bus.o_wr_valid, o_idle);
            end
        end
    endtask

    task automatic test_packing();
        bus.i_wr_ready = 1'b1;
        set_pix(10'd3, 9'd0, 8'hF8, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        checks++; if (bus.o_wr_valid !== 1'b0) begin errors++; $display("FAIL pack_t1 got %b want 0", bus.o_wr_valid); end
        @(negedge clk);
        checks++; if (wr_obs !== {1'b1, 2'b10, 18'h00001, 32'h041F_0000}) begin
            errors++; $display("FAIL pack_write got %h want %h", wr_obs, {1'b1, 2'b10, 18'h00001, 32'h041F_0000});
        end
        @(negedge clk);
        checks++; if (bus.o_wr_valid !== 1'b0 || o_idle !== 1'b1) begin
            errors++; $display("FAIL pack_after got valid=%b idle=%b want 0/1", bus.o_wr_valid, o_idle);
        end
    endtask

    task automatic test_pair();
        bus.i_wr_ready = 1'b1;
        set_pix(10'd10, 9'd5, 8'hF8, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL pair_ready got %b want 1", bus.o_ready); end
        set_pix(10'd11, 9'd5, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        checks++; if (bus.o_wr_valid !== 1'b0) begin errors++; $display("FAIL pair_early got %b want 0", bus.o_wr_valid); end
        @(negedge clk);
        checks++; if (wr_obs !== {1'b1, 2'b11, 18'h00A05, 32'hFFFF_041F}) begin
            errors++; $display("FAIL pair_write got %h want %h", wr_obs, {1'b1, 2'b11, 18'h00A05, 32'hFFFF_041F});
        end
        @(negedge clk);
        checks++; if (bus.o_wr_valid !== 1'b0) begin errors++; $display("FAIL pair_dup got %b want 0", bus.o_wr_valid); end
    endtask

    task automatic test_dither();
        int   dx[4]   = '{0, 2, 2, 0};
        int   dy[4]   = '{0, 1, 1, 0};
        int   dr[4]   = '{8'h87, 8'h87, 8'hFE, 8'h02};
        int   er5[4]  = '{16, 17, 31, 0};
        int   eadr[4] = '{18'h00000, 18'h00201, 18'h00201, 18'h00000};
        logic [52:0] exp_w;
        bus.i_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_pix(10'(dx[i]), 9'(dy[i]), 8'(dr[i]), 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            set_pix(10'(dx[i] + 1), 9'(dy[i]), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            bus.i_valid = 1'b0;
            @(negedge clk);
            exp_w = {1'b1, 2'b11, 18'(eadr[i]), 16'h0000, 11'h000, 5'(er5[i])};
            checks++; if (wr_obs !== exp_w) begin
                errors++; $display("FAIL dither_%0d got %h want %h", i, wr_obs, exp_w);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_break();
        bus.i_wr_ready = 1'b1;
        set_pix(10'd4, 9'd2, 8'hF8, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_pix(10'd8, 9'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        checks++; if (wr_obs !== {1'b1, 2'b01, 18'h00402, 32'h0000_041F}) begin
            errors++; $display("FAIL break_first got %h want %h", wr_obs, {1'b1, 2'b01, 18'h00402, 32'h0000_041F});
        end
        @(negedge clk);
        checks++; if (bus.o_wr_valid !== 1'b0 || o_idle !== 1'b0) begin
            errors++; $display("FAIL break_held got valid=%b idle=%b want 0/0", bus.o_wr_valid, o_idle);
        end
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL break_flush_ready got %b want 0", bus.o_ready); end
        @(negedge clk);
        checks++; if (wr_obs !== {1'b1, 2'b01, 18'h00404, 32'h0000_8000}) begin
            errors++; $display("FAIL break_drain got %h want %h", wr_obs, {1'b1, 2'b01, 18'h00404, 32'h0000_8000});
        end
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL break_drain_ready got %b want 0", bus.o_ready); end
        @(negedge clk);
        checks++; if (o_idle !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_wr_valid !== 1'b0) begin
            errors++; $display("FAIL break_end got idle=%b ready=%b valid=%b want 1/1/0", o_idle, bus.o_ready, bus.o_wr_valid);
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          nwr = 0;
        bit          prev_stall = 1'b0;
        bit          saw_ready_low = 1'b0;
        logic [52:0] prev_w = '0;
        logic [52:0] exp_w;
        for (int c = 0; c < 25; c++) begin
            bus.i_wr_ready = (c < 5) ? 1'b0 : 1'b1;
            if (sent < 4) begin
                set_pix(10'(2 * sent + 1), 9'd3, 8'(8 * (sent + 1)), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++; if (wr_obs !== prev_w) begin
                    errors++; $display("FAIL bp_stable cyc %0d got %h want %h", c, wr_obs, prev_w);
                end
            end
            if (bus.o_wr_valid && bus.i_wr_ready) begin
                exp_w = {1'b1, 2'b10, 18'h00600 + 18'(nwr), 16'(nwr + 1), 16'h0000};
                if (nwr < 4) begin
                    checks++; if (wr_obs !== exp_w) begin
                        errors++; $display("FAIL bp_write_%0d got %h want %h", nwr, wr_obs, exp_w);
                    end
                end
                nwr++;
            end
            if (c < 5 && sent < 4 && !bus.o_ready) saw_ready_low = 1'b1;
            if (bus.i_valid && bus.o_ready) sent++;
            prev_stall = bus.o_wr_valid && !bus.i_wr_ready;
            prev_w = wr_obs;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        checks++; if (nwr != 4) begin errors++; $display("FAIL bp_count got %0d want 4", nwr); end
        checks++; if (!saw_ready_low) begin errors++; $display("FAIL bp_ready_drop got 0 want 1"); end
        checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL bp_idle got %b want 1", o_idle); end
    endtask

    task automatic test_flush_same();
        int nwr = 0;
        bit idle_seen = 1'b0;
        bus.i_wr_ready = 1'b1;
        set_pix(10'd6, 9'd1, 8'hF8, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
        i_flush = 1'b1;
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL fs_accept got %b want 1", bus.o_ready); end
        @(negedge clk);
        bus.i_valid = 1'b0;
        i_flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.o_wr_valid) begin
                checks++; if (wr_obs !== {1'b1, 2'b01, 18'h00203, 32'h0000_041F}) begin
                    errors++; $display("FAIL fs_write got %h want %h", wr_obs, {1'b1, 2'b01, 18'h00203, 32'h0000_041F});
                end
                nwr++;
            end
            if (o_idle) idle_seen = 1'b1;
            if (!idle_seen) begin
                checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL fs_ready_low cyc %0d got %b want 0", c, bus.o_ready); end
            end
            @(negedge clk);
        end
        checks++; if (nwr != 1) begin errors++; $display("FAIL fs_count got %0d want 1", nwr); end
        checks++; if (!idle_seen) begin errors++; $display("FAIL fs_idle got 0 want 1"); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL fs_ready_end got %b want 1", bus.o_ready); end
    endtask

    initial begin
        test_reset();
        test_packing();
        test_pair();
        test_dither();
        test_break();
        test_backpressure();
        test_flush_same();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
